// File: rtl/spi_psram_responder.sv
// SPI mode-0 responder emulating a serial PSRAM (reset-enable, reset, write,
// read with 24-bit address) backed by a 2^ADDR_BITS byte array. All SPI pins
// are oversampled with the system clock.
module spi_psram_responder #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk_i,
  input  logic spi_cs_i,
  input  logic spi_data_i,
  output logic spi_data_o,
  output logic rst_cmd_o,
  output logic err_o
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  localparam logic [7:0] OpWrite = 8'h02;
  localparam logic [7:0] OpRead  = 8'h03;
  localparam logic [7:0] OpRstEn = 8'h66;
  localparam logic [7:0] OpRst   = 8'h99;

  typedef enum logic [2:0] {StIdle, StOpcode, StAddr, StWdata, StRdata, StIgnore} state_e;

  state_e state_q, state_d;
  logic [2:0] sck_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] rd_sh_q, rd_sh_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic miso_q, miso_d;
  logic flag_q, flag_d;
  logic armed_q, armed_d;
  logic rst_cmd_q, rst_cmd_d;
  logic err_q, err_d;

  logic [7:0] mem [Depth];
  logic [7:0] rd_byte;
  logic [7:0] wr_byte;
  logic mem_we;
  logic sck_rise, sck_fall, cs_high, mosi;
  logic exact8, no_bits;

  // Synchronizers; CS resets low so a transaction cut by reset is not re-entered
  // until CS has been seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= 3'b000;
      cs_sync_q   <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_data_i};
    end
  end

  // Edge detection and transaction classification at CS rise.
  always_comb begin
    sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    cs_high  = cs_sync_q[1];
    mosi     = mosi_sync_q[1];
    rd_byte  = mem[ptr_q];
    wr_byte  = {shift_q[6:0], mosi};
    // IGNORE with no further rises means exactly the 8 opcode bits were sent.
    exact8   = (state_q == StIgnore) && (cnt_q == 5'd0);
    no_bits  = (state_q == StOpcode) && (cnt_q == 5'd0);
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    opcode_d  = opcode_q;
    ptr_d     = ptr_q;
    rd_sh_d   = rd_sh_q;
    miso_d    = miso_q;
    flag_d    = flag_q;
    armed_d   = armed_q | cs_high;
    rst_cmd_d = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    if (cs_high) begin
      state_d = StIdle;
      cnt_d   = 5'd0;
      miso_d  = 1'b0;
      if (state_q != StIdle) begin
        if (exact8 && (opcode_q == OpRstEn)) begin
          flag_d = 1'b1;
        end else if (exact8 && (opcode_q == OpRst) && flag_q) begin
          rst_cmd_d = 1'b1;
          flag_d    = 1'b0;
        end else if (!no_bits) begin
          flag_d = 1'b0;
        end
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (armed_q) begin
            state_d = StOpcode;
            cnt_d   = 5'd0;
          end
        end
        StOpcode: begin
          if (sck_rise) begin
            shift_d = wr_byte;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              opcode_d = wr_byte;
              cnt_d    = 5'd0;
              case (wr_byte)
                OpWrite, OpRead: state_d = StAddr;
                OpRstEn, OpRst:  state_d = StIgnore;
                default: begin
                  state_d = StIgnore;
                  err_d   = 1'b1;
                end
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            // Upper address bits fall off the top of the pointer.
            ptr_d = {ptr_q[ADDR_BITS-2:0], mosi};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d   = 5'd0;
              state_d = (opcode_q == OpWrite) ? StWdata : StRdata;
            end
          end
        end
        StWdata: begin
          if (sck_rise) begin
            shift_d = wr_byte;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              mem_we = 1'b1;
              ptr_d  = ptr_q + 1'b1;
              cnt_d  = 5'd0;
            end
          end
        end
        StRdata: begin
          if (sck_fall) begin
            if (cnt_q == 5'd0) begin
              miso_d  = rd_byte[7];
              rd_sh_d = {rd_byte[6:0], 1'b0};
              ptr_d   = ptr_q + 1'b1;
              cnt_d   = 5'd1;
            end else begin
              miso_d  = rd_sh_q[7];
              rd_sh_d = {rd_sh_q[6:0], 1'b0};
              cnt_d   = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
            end
          end
        end
        StIgnore: begin
          if (sck_rise) cnt_d = 5'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      shift_q   <= 8'h00;
      opcode_q  <= 8'h00;
      rd_sh_q   <= 8'h00;
      ptr_q     <= '0;
      miso_q    <= 1'b0;
      flag_q    <= 1'b0;
      armed_q   <= 1'b0;
      rst_cmd_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      opcode_q  <= opcode_d;
      rd_sh_q   <= rd_sh_d;
      ptr_q     <= ptr_d;
      miso_q    <= miso_d;
      flag_q    <= flag_d;
      armed_q   <= armed_d;
      rst_cmd_q <= rst_cmd_d;
      err_q     <= err_d;
    end
  end

  // Byte array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= wr_byte;
  end

  assign spi_data_o = miso_q;
  assign rst_cmd_o  = rst_cmd_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_spi_psram_responder.sv
// Self-checking bench for spi_psram_responder: transaction-level memory/flag
// model, per-cycle output comparison and directed plus random SPI traffic.
module tb_spi_psram_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic sck, cs, mosi;
  logic spi_data_o, rst_cmd_o, err_o;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic tx[$];
  logic [7:0] rx[$];

  // Model state
  logic [7:0] m_mem [1024];
  bit m_valid [1024];
  bit m_flag;
  logic [7:0] m_op, m_wbyte;
  int m_addr;
  int err_due[$];
  int rst_due[$];
  int sch_t[$];
  logic sch_v[$];
  bit sch_k[$];
  logic exp_miso = 1'b0;
  bit exp_known = 1'b1;
  int n_err_pulse = 0;
  int n_rst_pulse = 0;
  int last_wr = 0;

  spi_psram_responder #(.ADDR_BITS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk_i  (sck),
    .spi_cs_i   (cs),
    .spi_data_i (mosi),
    .spi_data_o (spi_data_o),
    .rst_cmd_o  (rst_cmd_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx.push_back(v[i]);
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) tx.push_back(1'($urandom_range(0, 1)));
  endtask

  // Model reaction to SCK rise number r (1-based) carrying bit b.
  task automatic model_rise(input int r, input logic b);
    int idx;
    if (r <= 8) begin
      m_op = {m_op[6:0], b};
      if (r == 8 && !(m_op inside {8'h02, 8'h03, 8'h66, 8'h99})) err_due.push_back(cyc + 3);
    end else if (r <= 32) begin
      m_addr = ((m_addr << 1) | int'(b)) & 32'h00FF_FFFF;
    end else if (m_op == 8'h02) begin
      m_wbyte = {m_wbyte[6:0], b};
      if ((r - 32) % 8 == 0) begin
        idx = (m_addr + (r - 32) / 8 - 1) % 1024;
        m_mem[idx] = m_wbyte;
        m_valid[idx] = 1'b1;
      end
    end
  endtask

  // Model reaction to the SCK fall following rise f.
  task automatic model_fall(input int f);
    int j, idx;
    if (m_op == 8'h03 && f >= 32) begin
      j = f - 32;
      idx = (m_addr + j / 8) % 1024;
      sch_t.push_back(cyc + 3);
      sch_v.push_back(m_valid[idx] ? m_mem[idx][7 - (j % 8)] : 1'b0);
      sch_k.push_back(m_valid[idx]);
    end
  endtask

  task automatic model_cs_rise(input int n);
    sch_t.push_back(cyc + 3);
    sch_v.push_back(1'b0);
    sch_k.push_back(1'b1);
    if (n == 8 && m_op == 8'h66) begin
      m_flag = 1'b1;
    end else if (n == 8 && m_op == 8'h99 && m_flag) begin
      rst_due.push_back(cyc + 3);
      m_flag = 1'b0;
    end else if (n > 0) begin
      m_flag = 1'b0;
    end
  endtask

  // Drive the bits in tx as one CS-low transaction; abort_fall > 0 stops after that fall.
  task automatic xfer(input int abort_fall);
    logic [7:0] rxb;
    rxb = 8'h00;
    m_op = 8'h00;
    m_addr = 0;
    m_wbyte = 8'h00;
    rx.delete();
    @(negedge clk);
    cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < tx.size(); i++) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      model_rise(i + 1, tx[i]);
      repeat (5) @(negedge clk);
      if (i + 1 >= 33) begin
        rxb = {rxb[6:0], spi_data_o};
        if ((i + 1 - 33) % 8 == 7) rx.push_back(rxb);
      end
      sck = 1'b0;
      model_fall(i + 1);
      if (abort_fall == i + 1) begin
        repeat (4) @(negedge clk);
        tx.delete();
        return;
      end
    end
    repeat (5) @(negedge clk);
    cs = 1'b1;
    model_cs_rise(tx.size());
    repeat (6) @(negedge clk);
    tx.delete();
  endtask

  task automatic do_write(input int addr, input int nbytes, input logic [31:0] data);
    push_bits(8'h02, 8);
    push_bits(addr, 24);
    for (int k = nbytes - 1; k >= 0; k--) push_bits(data >> (8 * k), 8);
    xfer(0);
  endtask

  task automatic do_read(input int addr, input int nbytes);
    push_bits(8'h03, 8);
    push_bits(addr, 24);
    push_rand_bits(8 * nbytes);
    xfer(0);
  endtask

  // Per-cycle comparison of all outputs against the model schedule.
  initial begin
    logic exp_e, exp_r;
    forever begin
      @(posedge clk);
      #2;
      while (sch_t.size() > 0 && sch_t[0] <= cyc) begin
        exp_miso = sch_v.pop_front();
        exp_known = sch_k.pop_front();
        void'(sch_t.pop_front());
      end
      exp_e = 1'b0;
      exp_r = 1'b0;
      if (err_due.size() > 0 && err_due[0] == cyc) begin
        exp_e = 1'b1;
        void'(err_due.pop_front());
      end
      if (rst_due.size() > 0 && rst_due[0] == cyc) begin
        exp_r = 1'b1;
        void'(rst_due.pop_front());
      end
      if (err_o === 1'b1) n_err_pulse++;
      if (rst_cmd_o === 1'b1) n_rst_pulse++;
      if (exp_known) chk("miso", spi_data_o, exp_miso);
      chk("err_o", err_o, exp_e);
      chk("rst_cmd_o", rst_cmd_o, exp_r);
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int kind, addr, nb, op;
    rst_n = 1'b0;
    sck = 1'b0;
    cs = 1'b1;
    mosi = 1'b0;
    m_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", spi_data_o, 1'b0);
    chk("reset_rst_cmd", rst_cmd_o, 1'b0);
    chk("reset_err", err_o, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Write then read back
    do_write(32'h10, 4, 32'hDEAD_BEEF);
    do_read(32'h10, 4);
    chk("rd_b0", rx[0], 8'hDE);
    chk("rd_b1", rx[1], 8'hAD);
    chk("rd_b2", rx[2], 8'hBE);
    chk("rd_b3", rx[3], 8'hEF);

    // Pointer wrap and ignored upper address bits
    do_write(32'h3FF, 2, 32'h1122);
    chk("model_wrap", m_mem[0], 8'h22);
    do_read(32'h0, 1);
    chk("rd_wrap", rx[0], 8'h22);
    do_read(32'hFF_FFFF, 1);
    chk("rd_upper_ign", rx[0], 8'h11);

    // Reset sequences
    push_bits(8'h66, 8); xfer(0);
    push_bits(8'h99, 8); xfer(0);
    chk("rst_pulse_a", n_rst_pulse, 1);
    push_bits(8'h99, 8); xfer(0);
    push_bits(8'h66, 8); xfer(0);
    push_bits(8'h03, 8); push_bits(4'hA, 4); xfer(0);
    push_bits(8'h99, 8); xfer(0);
    chk("rst_pulse_b", n_rst_pulse, 1);
    push_bits(8'h66, 8); xfer(0);
    xfer(0);
    push_bits(8'h99, 8); xfer(0);
    chk("rst_pulse_c", n_rst_pulse, 2);
    chk("err_none", n_err_pulse, 0);

    // Aborted write keeps partial byte out of memory
    do_write(32'h20, 2, 32'h005A);
    push_bits(8'h02, 8); push_bits(32'h20, 24); push_bits(8'hA5, 8); push_bits(4'h3, 4);
    xfer(0);
    do_read(32'h20, 2);
    chk("abort_b0", rx[0], 8'hA5);
    chk("abort_b1", rx[1], 8'h5A);

    // Unknown opcode
    push_bits(8'hAB, 8); push_bits(32'h10, 24); xfer(0);
    chk("err_pulse", n_err_pulse, 1);
    do_read(32'h10, 1);
    chk("unk_mem", rx[0], 8'hDE);

    // Reset during read data
    push_bits(8'h03, 8); push_bits(32'h10, 24); push_rand_bits(32);
    xfer(35);
    rst_n = 1'b0;
    sch_t.delete(); sch_v.delete(); sch_k.delete();
    err_due.delete(); rst_due.delete();
    exp_miso = 1'b0;
    exp_known = 1'b1;
    m_flag = 1'b0;
    #1;
    chk("miso_at_reset", spi_data_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    do_read(32'h10, 4);
    chk("rec_b0", rx[0], 8'hDE);
    chk("rec_b1", rx[1], 8'hAD);
    chk("rec_b2", rx[2], 8'hBE);
    chk("rec_b3", rx[3], 8'hEF);

    // Random traffic
    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        addr = $urandom_range(0, 32'h00FF_FFFF);
        nb = $urandom_range(1, 4);
        do_write(addr, nb, $urandom);
        last_wr = addr;
      end else if (kind <= 7) begin
        addr = (last_wr & 32'h3FF) | ($urandom_range(0, 16383) << 10);
        do_read(addr, $urandom_range(1, 4));
      end else if (kind == 8) begin
        op = $urandom_range(0, 255);
        if (op == 2 || op == 3) op = 8'hAB;
        push_bits(op, 8);
        push_rand_bits($urandom_range(0, 16));
        xfer(0);
      end else begin
        push_bits(8'h66, 8); xfer(0);
        push_bits(8'h99, 8); xfer(0);
      end
    end

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
